key_conditioner: RTL and testbench

Front-end stage for the two user push-buttons that drive the 7-segment pattern selector. It takes raw, asynchronous, bouncing button inputs and synchronises each to `clk`. It then debounces each one and emits a clean one-cycle press pulse per key, plus optional auto-repeat while a key is held. The pulse outputs connect directly to the selector's `key_a`/`key_b` step inputs: A steps down, B steps up.

---
 rtl/key_conditioner_if.sv | 29 ++
 rtl/key_conditioner.sv | 164 ++++++++++++++++
 tb/tb_key_conditioner.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/key_conditioner_if.sv
// Button front-end bundle: raw bouncing inputs in, conditioned pulses and levels out.
interface key_conditioner_if;
    logic key_a_raw;
    logic key_b_raw;
    logic key_a;
    logic key_b;
    logic key_a_level;
    logic key_b_level;

    // Board/bench side: drives the raw buttons and consumes the conditioned outputs.
    modport master (
        output key_a_raw,
        output key_b_raw,
        input  key_a,
        input  key_b,
        input  key_a_level,
        input  key_b_level
    );

    // Conditioner side.
    modport slave (
        input  key_a_raw,
        input  key_b_raw,
        output key_a,
        output key_b,
        output key_a_level,
        output key_b_level
    );
endinterface

// File: rtl/key_conditioner.sv
// Two-key push-button conditioner: synchronise, debounce, press pulse and auto-repeat.
// Key A (index 0) steps the pattern selector down, key B (index 1) steps it up.
//
// Repeat FSM states (one per key):
//   state      | meaning
//   -----------+-----------------------------------------------------------
//   IDLE       | key released (debounced level 0), waiting for a press
//   HOLD_DELAY | press pulse sent, counting the initial delay to first repeat
//   REPEAT     | key held past the delay, one pulse every REPEAT_PERIOD cycles
module key_conditioner #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int ACTIVE_LOW      = 1,
    parameter int REPEAT_EN       = 1,
    parameter int REPEAT_DELAY    = 64,
    parameter int REPEAT_PERIOD   = 16
) (
    input  logic             clk,
    input  logic             rst,
    key_conditioner_if.slave kif
);

    localparam int DW = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RW = $clog2(RMAX) + 1;
    localparam logic RELEASED_RAW = (ACTIVE_LOW != 0) ? 1'b1 : 1'b0;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        HOLD_DELAY = 2'd1,
        REPEAT     = 2'd2
    } rep_state_t;

    logic [1:0] raw;
    logic [1:0] sync1;
    logic [1:0] sync2;
    logic [1:0] pressed;
    logic [1:0] level;
    logic [1:0] level_nxt;
    logic [1:0] press_evt;
    logic [1:0] rep_evt;
    logic [1:0] pulse;
    logic [1:0] pulse_nxt;
    logic       both_press;
    logic       both_held;

    assign raw = {kif.key_b_raw, kif.key_a_raw};

    // Two-flop synchroniser, then a polarity-normalising stage so pressed = 1.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1   <= {2{RELEASED_RAW}};
            sync2   <= {2{RELEASED_RAW}};
            pressed <= 2'b00;
        end else begin
            sync1   <= raw;
            sync2   <= sync1;
            pressed <= (ACTIVE_LOW != 0) ? ~sync2 : sync2;
        end
    end

    for (genvar k = 0; k < 2; k++) begin : g_ch
        logic [DW-1:0] db_cnt;
        logic          level_q;
        logic          toggle;
        rep_state_t    state;
        logic [RW-1:0] rep_cnt;
        logic          delay_done;
        logic          period_done;

        assign toggle      = (pressed[k] != level_q) && (db_cnt == DW'(DEBOUNCE_CYCLES - 1));
        assign delay_done  = (rep_cnt == RW'(REPEAT_DELAY - 1));
        assign period_done = (rep_cnt == RW'(REPEAT_PERIOD - 1));

        assign level[k]     = level_q;
        assign level_nxt[k] = level_q ^ toggle;
        // The press pulse lands in the same cycle the debounced level first reads 1.
        assign press_evt[k] = ~level_q & toggle;
        // A release edge in the same cycle cancels any pending repeat.
        assign rep_evt[k]   = level_q & ~toggle &
                              (((state == HOLD_DELAY) && (REPEAT_EN != 0) && delay_done) ||
                               ((state == REPEAT) && period_done));

        // Debounce: level only follows the synchronised input after it has
        // disagreed for DEBOUNCE_CYCLES consecutive cycles.
        always_ff @(posedge clk) begin
            if (rst) begin
                db_cnt  <= '0;
                level_q <= 1'b0;
            end else if (pressed[k] == level_q) begin
                db_cnt  <= '0;
            end else if (toggle) begin
                db_cnt  <= '0;
                level_q <= ~level_q;
            end else begin
                db_cnt  <= db_cnt + 1'b1;
            end
        end

        // Repeat FSM: tracks hold time and schedules repeat pulses.
        always_ff @(posedge clk) begin
            if (rst) begin
                state   <= IDLE;
                rep_cnt <= '0;
            end else if (level_q && toggle) begin
                state   <= IDLE;
                rep_cnt <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        rep_cnt <= '0;
                        if (press_evt[k]) begin
                            state <= HOLD_DELAY;
                        end
                    end
                    HOLD_DELAY: begin
                        // With repeat disabled the counter parks at its compare value.
                        if (delay_done) begin
                            if (REPEAT_EN != 0) begin
                                state   <= REPEAT;
                                rep_cnt <= '0;
                            end
                        end else begin
                            rep_cnt <= rep_cnt + 1'b1;
                        end
                    end
                    REPEAT: begin
                        if (period_done) begin
                            rep_cnt <= '0;
                        end else begin
                            rep_cnt <= rep_cnt + 1'b1;
                        end
                    end
                    default: begin
                        state   <= IDLE;
                        rep_cnt <= '0;
                    end
                endcase
            end
        end
    end

    // Cross-key masking: coincident presses cancel each other, and repeats
    // are silenced while both keys are held, so the selector never sees both steps.
    always_comb begin
        both_press = press_evt[0] & press_evt[1];
        both_held  = level_nxt[0] & level_nxt[1];
        pulse_nxt  = ({2{~both_press}} & press_evt) | ({2{~both_held}} & rep_evt);
    end

    // Registered one-cycle step pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            pulse <= 2'b00;
        end else begin
            pulse <= pulse_nxt;
        end
    end

    assign kif.key_a       = pulse[0];
    assign kif.key_b       = pulse[1];
    assign kif.key_a_level = level[0];
    assign kif.key_b_level = level[1];

endmodule

// File: tb/tb_key_conditioner.sv
// Directed bench for key_conditioner with DEBOUNCE_CYCLES=4, REPEAT_DELAY=8,
// REPEAT_PERIOD=4, active-low keys. Raw inputs change between edges; a change
// made in cycle 0 first shows on level/pulse at the negedge after edge 7.
`timescale 1ns/1ps
module tb_key_conditioner;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    key_conditioner_if bus ();
    key_conditioner_if bus_nr ();

    key_conditioner #(
        .DEBOUNCE_CYCLES(4), .ACTIVE_LOW(1), .REPEAT_EN(1),
        .REPEAT_DELAY(8), .REPEAT_PERIOD(4)
    ) dut (
        .clk(clk), .rst(rst), .kif(bus.slave)
    );

    key_conditioner #(
        .DEBOUNCE_CYCLES(4), .ACTIVE_LOW(1), .REPEAT_EN(0),
        .REPEAT_DELAY(8), .REPEAT_PERIOD(4)
    ) dut_nr (
        .clk(clk), .rst(rst), .kif(bus_nr.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic settle();
        bus.key_a_raw    = 1'b1;
        bus.key_b_raw    = 1'b1;
        bus_nr.key_a_raw = 1'b1;
        bus_nr.key_b_raw = 1'b1;
        repeat (14) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.key_a_raw    = 1'b0;
        bus.key_b_raw    = 1'b0;
        bus_nr.key_a_raw = 1'b1;
        bus_nr.key_b_raw = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); @(negedge clk);
            n_checks++;
            if ({bus.key_a, bus.key_b, bus.key_a_level, bus.key_b_level} !== 4'b0000) begin
                n_fail++;
                $display("FAIL reset_outputs cyc=%0d got %b%b%b%b exp 0000", i,
                         bus.key_a, bus.key_b, bus.key_a_level, bus.key_b_level);
            end
        end
        rst = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            @(posedge clk); @(negedge clk);
            n_checks++;
            if (bus.key_a_level !== (c >= 7) || bus.key_b_level !== (c >= 7)) begin
                n_fail++;
                $display("FAIL reset_level c=%0d got a=%b b=%b exp %b", c,
                         bus.key_a_level, bus.key_b_level, (c >= 7));
            end
            n_checks++;
            if (bus.key_a !== 1'b0 || bus.key_b !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_coincident_press c=%0d got a=%b b=%b exp 0 0", c,
                         bus.key_a, bus.key_b);
            end
        end
        settle();
    endtask

    task automatic test_clean_press();
        logic exp_l;
        logic exp_p;
        bus.key_a_raw = 1'b0;
        for (int c = 1; c <= 16; c++) begin
            @(posedge clk); @(negedge clk);
            exp_l = (c >= 7) && (c < 12);
            exp_p = (c == 7);
            n_checks++;
            if (bus.key_a_level !== exp_l) begin
                n_fail++;
                $display("FAIL clean_level c=%0d got %b exp %b", c, bus.key_a_level, exp_l);
            end
            n_checks++;
            if (bus.key_a !== exp_p || bus.key_b !== 1'b0) begin
                n_fail++;
                $display("FAIL clean_pulse c=%0d got a=%b b=%b exp a=%b b=0", c,
                         bus.key_a, bus.key_b, exp_p);
            end
            if (c == 5) bus.key_a_raw = 1'b1;
        end
        settle();
    endtask

    task automatic test_bounce();
        // value of key_b_raw during cycle j: 0 x3, 1 x1, 0 x3, 1 x2, then 0
        logic [8:0] pattern;
        logic       exp_l;
        pattern = 9'b110001000;
        bus.key_b_raw = pattern[0];
        for (int c = 1; c <= 18; c++) begin
            @(posedge clk); @(negedge clk);
            exp_l = (c >= 16);
            n_checks++;
            if (bus.key_b_level !== exp_l) begin
                n_fail++;
                $display("FAIL bounce_level c=%0d got %b exp %b", c, bus.key_b_level, exp_l);
            end
            n_checks++;
            if (bus.key_b !== (c == 16) || bus.key_a !== 1'b0) begin
                n_fail++;
                $display("FAIL bounce_pulse c=%0d got b=%b a=%b exp b=%b a=0", c,
                         bus.key_b, bus.key_a, (c == 16));
            end
            bus.key_b_raw = (c < 9) ? pattern[c] : 1'b0;
        end
        settle();
    endtask

    task automatic test_auto_repeat();
        logic exp_p;
        bus.key_b_raw = 1'b0;
        for (int c = 1; c <= 52; c++) begin
            @(posedge clk); @(negedge clk);
            exp_p = (c == 7) || (c >= 15 && c <= 43 && ((c - 15) % 4) == 0);
            n_checks++;
            if (bus.key_b !== exp_p) begin
                n_fail++;
                $display("FAIL repeat_pulse c=%0d got %b exp %b", c, bus.key_b, exp_p);
            end
            n_checks++;
            if (bus.key_b_level !== (c >= 7 && c < 47)) begin
                n_fail++;
                $display("FAIL repeat_level c=%0d got %b exp %b", c, bus.key_b_level,
                         (c >= 7 && c < 47));
            end
            if (c == 40) bus.key_b_raw = 1'b1;
        end
        settle();
    endtask

    task automatic test_reset_mid_hold();
        bus.key_a_raw = 1'b0;
        repeat (20) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); @(negedge clk);
        n_checks++;
        if (bus.key_a_level !== 1'b0 || bus.key_a !== 1'b0) begin
            n_fail++;
            $display("FAIL midhold_reset got level=%b pulse=%b exp 0 0", bus.key_a_level, bus.key_a);
        end
        rst = 1'b0;
        for (int c = 1; c <= 9; c++) begin
            @(posedge clk); @(negedge clk);
            n_checks++;
            if (bus.key_a !== (c == 7) || bus.key_a_level !== (c >= 7)) begin
                n_fail++;
                $display("FAIL midhold_repress c=%0d got pulse=%b level=%b exp %b %b", c,
                         bus.key_a, bus.key_a_level, (c == 7), (c >= 7));
            end
        end
        settle();
    endtask

    task automatic test_both_held();
        logic exp_a;
        logic exp_b;
        bus.key_a_raw = 1'b0;
        for (int c = 1; c <= 60; c++) begin
            @(posedge clk); @(negedge clk);
            exp_a = (c == 7) || (c == 15) || (c >= 47 && ((c - 47) % 4) == 0);
            exp_b = (c == 17);
            n_checks++;
            if (bus.key_a !== exp_a) begin
                n_fail++;
                $display("FAIL both_pulse_a c=%0d got %b exp %b", c, bus.key_a, exp_a);
            end
            n_checks++;
            if (bus.key_b !== exp_b) begin
                n_fail++;
                $display("FAIL both_pulse_b c=%0d got %b exp %b", c, bus.key_b, exp_b);
            end
            n_checks++;
            if (bus.key_a_level !== (c >= 7) || bus.key_b_level !== (c >= 17 && c < 47)) begin
                n_fail++;
                $display("FAIL both_levels c=%0d got a=%b b=%b exp a=%b b=%b", c,
                         bus.key_a_level, bus.key_b_level, (c >= 7), (c >= 17 && c < 47));
            end
            if (c == 10) bus.key_b_raw = 1'b0;
            if (c == 40) bus.key_b_raw = 1'b1;
        end
        settle();
    endtask

    task automatic test_repeat_disabled();
        bus_nr.key_a_raw = 1'b0;
        for (int c = 1; c <= 60; c++) begin
            @(posedge clk); @(negedge clk);
            n_checks++;
            if (bus_nr.key_a !== (c == 7)) begin
                n_fail++;
                $display("FAIL norepeat_pulse c=%0d got %b exp %b", c, bus_nr.key_a, (c == 7));
            end
            n_checks++;
            if (bus_nr.key_a_level !== (c >= 7 && c < 57)) begin
                n_fail++;
                $display("FAIL norepeat_level c=%0d got %b exp %b", c, bus_nr.key_a_level,
                         (c >= 7 && c < 57));
            end
            if (c == 50) bus_nr.key_a_raw = 1'b1;
        end
        settle();
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_clean_press();
        test_bounce();
        test_auto_repeat();
        test_reset_mid_hold();
        test_both_held();
        test_repeat_disabled();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
